bch_codeword_framer: RTL and testbench
======================================

// Module: bch_codeword_framer
// PURPOSE
//  Upstream/downstream sequencer around the serial BCH LFSR encoder.
//  - Accepts a K-bit parallel message (valid/ready) and drives it MSB-first into the encoder.
//  - Collects the N-K serial parity bits the encoder returns.
//  - Presents the systematic N-bit codeword {msg, parity} on a valid/ready output.
//  - Issues a one-cycle encoder clear between codewords.
// PARAMETERS
//  N   63  codeword length (bits)
//  K   24  message length (bits); N-K = parity length, must be >= 1
//  TO  255 parity-stall timeout in cycles; only used with BCH_FRAMER_TIMEOUT_EN
// PORTS
//  clk            in   1    single clock; all logic on rising edge
//  rst            in   1    synchronous, active-high reset
//  msg_in         in   K    parallel message; msg_in[K-1] is transmitted first
//  msg_valid      in   1    message offered
//  msg_ready      out  1    framer accepts msg_in this cycle when msg_valid & msg_ready
//  enc_data       out  1    serial message bit to encoder
//  enc_valid      out  1    encoder shift enable (message and parity phases)
//  enc_clr        out  1    one-cycle encoder state clear pulse
//  enc_ecc        in   1    serial parity bit from encoder
//  enc_ecc_valid  in   1    enc_ecc holds a parity bit this cycle
//  cw_out         out  N    codeword: [N-1:N-K] = message, [N-K-1:0] = parity
//  cw_valid       out  1    cw_out valid; held until accepted
//  cw_ready       in   1    downstream accepts when cw_valid & cw_ready
//  err_timeout    out  1    sticky parity-stall flag (0 when macro absent)
// BEHAVIOUR
//  - Reset values: msg_ready=0, enc_data=0, enc_valid=0, enc_clr=0, cw_out=0, cw_valid=0, err_timeout=0.
//    State goes to CLR, so the encoder is cleared once after every reset.
//  - FSM: CLR -> IDLE -> MSG -> PAR -> OUT -> CLR.
//  - CLR (1 cycle): enc_clr=1, enc_valid=0. Next state is IDLE.
//  - IDLE: msg_ready=1. On msg_valid, latch msg_in into the shift register and cw_out[N-1:N-K], then go to MSG.
//  - MSG (exactly K cycles): enc_valid=1, enc_data=msg_sr[K-1], then shift left.
//    A 6+ bit counter counts 0..K-1. After count K-1, go to PAR.
//  - PAR: enc_valid=1, enc_data=0.
//    - Each cycle with enc_ecc_valid=1 captures enc_ecc into the parity shift register (first bit lands in cw_out[N-K-1]).
//    - Cycles with enc_ecc_valid=0 are stalls: nothing is captured and the capture count does not advance.
//    - After N-K captures, go to OUT. The first OUT cycle has enc_valid=0.
//  - OUT: cw_valid=1 and cw_out stays stable. On cw_ready, cw_valid drops next cycle and the FSM goes to CLR.
//  - Latency (no stalls, cw_ready held 1): msg accept -> cw_valid = K + (N-K) + 1 = N+1 cycles.
//    Minimum period between accepts is N+3 cycles.
//  - msg_ready is 0 in every state except IDLE, and msg_valid is ignored there. No message is ever dropped or overwritten.
//  - enc_ecc_valid in any state other than PAR is ignored.
//  - If rst is asserted mid-codeword, the codeword in progress is discarded and no partial cw_valid is produced.
//  - Counters saturate at their terminal counts; no wrap-around is possible.
// CONFIGURATION
//  BCH_FRAMER_TIMEOUT_EN
//  - Defined:
//    - A stall counter runs in PAR and resets on every captured bit.
//    - If it reaches TO, err_timeout is set (sticky until rst).
//    - The codeword is abandoned with no cw_valid, and the FSM goes to CLR.
//  - Undefined: no counter. PAR waits indefinitely and err_timeout is tied to 0.
// TESTING
//  Bench drives a behavioural LFSR encoder with g = 40'hF69AC20921 (N=63, K=24).
//  1. msg_in=24'h000001, cw_ready=1 -> cw_out=63'h00000F69AC20921, cw_valid 64 cycles after accept.
//  2. msg_in=24'h000000 -> cw_out=0. A second msg_valid held during the codeword is accepted only in IDLE, 66 cycles after the first accept.
//  3. Encoder inserts enc_ecc_valid=0 every other PAR cycle -> same cw_out as scenario 1, cw_valid 39 cycles later than in scenario 1.
//  4. cw_ready=0 for 20 cycles in OUT -> cw_valid and cw_out stable throughout. Exactly one handshake occurs, then enc_clr pulses exactly once.
//  5. rst=1 for one cycle during MSG count 10 -> all outputs at reset values, enc_clr pulses next cycle, no cw_valid. A new message then encodes correctly.
//  6. (TIMEOUT_EN, TO=8) enc_ecc_valid held 0 in PAR -> err_timeout=1 after 8 stall cycles, no cw_valid, FSM returns to CLR.

Source files
------------

// File: rtl/bch_codeword_framer.sv
// -----------------------------------------------------------------------------
// bch_codeword_framer
//
// Sequencer around a serial BCH LFSR encoder. A K-bit message is taken on a
// valid/ready input, shifted MSB-first into the encoder, and the N-K parity
// bits returned serially by the encoder are collected. The systematic
// codeword {msg, parity} is then offered on a valid/ready output. A one-cycle
// encoder clear is issued between codewords and once after every reset.
//
// Optional feature macro: BCH_FRAMER_TIMEOUT_EN
//   Defined   : a parity-stall counter abandons the codeword after TO
//               consecutive stall cycles and sets the sticky err_timeout.
//   Undefined : the parity phase waits indefinitely; err_timeout is 0.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. A valid, once raised, is held with its data
// stable until that transfer.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   msg_in         K-bit message, msg_in[K-1] sent first
//   msg_valid/ready  message handshake (ready only in IDLE)
//   enc_data       serial message bit to the encoder
//   enc_valid      encoder shift enable (message and parity phases)
//   enc_clr        one-cycle encoder clear
//   enc_ecc        serial parity bit from the encoder
//   enc_ecc_valid  enc_ecc holds a parity bit this cycle
//   cw_out         codeword, [N-1:N-K] message, [N-K-1:0] parity
//   cw_valid/ready codeword handshake
//   err_timeout    sticky parity-stall flag
//   dbg_state      current FSM state encoding (CLR=0 IDLE=1 MSG=2 PAR=3 OUT=4)
// -----------------------------------------------------------------------------
module bch_codeword_framer #(
  parameter int          N  = 63,
  parameter int          K  = 24,
  parameter int unsigned TO = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] msg_in,
  input  logic         msg_valid,
  output logic         msg_ready,
  output logic         enc_data,
  output logic         enc_valid,
  output logic         enc_clr,
  input  logic         enc_ecc,
  input  logic         enc_ecc_valid,
  output logic [N-1:0] cw_out,
  output logic         cw_valid,
  input  logic         cw_ready,
  output logic         err_timeout,
  output logic [2:0]   dbg_state
);

  localparam int PW = N - K;
  localparam int CW = ($clog2(N + 1) > 6) ? $clog2(N + 1) : 6;
  localparam logic [CW-1:0] MSG_LAST = CW'(K - 1);
  localparam logic [CW-1:0] PAR_LAST = CW'(PW - 1);

  typedef enum logic [2:0] {
    S_CLR  = 3'd0,
    S_IDLE = 3'd1,
    S_MSG  = 3'd2,
    S_PAR  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [K-1:0]    msg_sr_q, msg_sr_d;
  logic [K-1:0]    cw_msg_q, cw_msg_d;
  logic [PW-1:0]   par_q, par_d;
  logic            timeout_hit;

`ifdef BCH_FRAMER_TIMEOUT_EN
  localparam int SW = $clog2(TO + 1);

  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;

  // The stall count clears on every captured bit and outside PAR, so only
  // an unbroken run of TO stall cycles abandons the codeword.
  always_comb begin
    stall_d     = '0;
    err_d       = err_q;
    timeout_hit = 1'b0;
    if (state_q == S_PAR && !enc_ecc_valid) begin
      if (stall_q == SW'(TO - 1)) begin
        timeout_hit = 1'b1;
        err_d       = 1'b1;
      end else begin
        stall_d = stall_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err_timeout = err_q & ~rst;
`else
  logic unused_to;
  assign unused_to   = ^TO;
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    msg_sr_d = msg_sr_q;
    cw_msg_d = cw_msg_q;
    par_d    = par_q;
    case (state_q)
      S_CLR: begin
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (msg_valid) begin
          msg_sr_d = msg_in;
          cw_msg_d = msg_in;
          cnt_d    = '0;
          state_d  = S_MSG;
        end
      end
      S_MSG: begin
        msg_sr_d = msg_sr_q << 1;
        if (cnt_q == MSG_LAST) begin
          cnt_d   = '0;
          state_d = S_PAR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PAR: begin
        if (timeout_hit) begin
          state_d = S_CLR;
        end else if (enc_ecc_valid) begin
          // Shift left with the new bit at the LSB: after PW captures the
          // first parity bit sits at par_q[PW-1].
          par_d = PW'({par_q, enc_ecc});
          if (cnt_q == PAR_LAST) begin
            state_d = S_OUT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_OUT: begin
        if (cw_ready) begin
          state_d = S_CLR;
        end
      end
      default: begin
        state_d = S_CLR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CLR;
      cnt_q    <= '0;
      msg_sr_q <= '0;
      cw_msg_q <= '0;
      par_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      msg_sr_q <= msg_sr_d;
      cw_msg_q <= cw_msg_d;
      par_q    <= par_d;
    end
  end

  // Outputs decode the state register and are forced to their reset values
  // while rst is high. Reset parks the FSM in CLR, so enc_clr pulses in the
  // first cycle after rst is released.
  assign msg_ready = ~rst & (state_q == S_IDLE);
  assign enc_valid = ~rst & ((state_q == S_MSG) | (state_q == S_PAR));
  assign enc_data  = ~rst & (state_q == S_MSG) & msg_sr_q[K-1];
  assign enc_clr   = ~rst & (state_q == S_CLR);
  assign cw_valid  = ~rst & (state_q == S_OUT);
  assign cw_out    = rst ? '0 : {cw_msg_q, par_q};
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bch_codeword_framer.sv
module tb_bch_codeword_framer;

  localparam int N = 63;
  localparam int K = 24;
`ifdef BCH_FRAMER_TIMEOUT_EN
  localparam int TO_B = 8;
`else
  localparam int TO_B = 255;
`endif
  localparam logic [38:0] G_LOW = 39'h769AC20921;  // g = 40'hF69AC20921
  localparam logic [2:0] ST_CLR  = 3'd0;
  localparam logic [2:0] ST_MSG  = 3'd2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [K-1:0] msg_in = '0;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic         enc_data, enc_valid, enc_clr;
  logic         enc_ecc, enc_ecc_valid;
  logic [N-1:0] cw_out;
  logic         cw_valid;
  logic         cw_ready = 1'b0;
  logic         err_timeout;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bch_codeword_framer #(.N(N), .K(K), .TO(TO_B)) dut (
    .clk(clk), .rst(rst),
    .msg_in(msg_in), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .enc_data(enc_data), .enc_valid(enc_valid), .enc_clr(enc_clr),
    .enc_ecc(enc_ecc), .enc_ecc_valid(enc_ecc_valid),
    .cw_out(cw_out), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // ---------------- behavioural serial LFSR encoder ----------------
  // stall_mode: 0 = parity every cycle, 1 = stall on alternate PAR cycles
  // (first PAR cycle stalls), 2 = stall forever.
  logic [38:0] m_r = '0;
  int          m_cnt = 0;
  logic        m_phase = 1'b0;
  int          stall_mode = 0;
  logic        force_ev = 1'b0;

  always @(posedge clk) begin
    if (enc_clr) begin
      m_r <= '0; m_cnt <= 0; m_phase <= 1'b0;
    end else if (enc_valid) begin
      if (m_cnt < K) begin
        m_r   <= {m_r[37:0], 1'b0} ^ (((enc_data ^ m_r[38]) != 1'b0) ? G_LOW : 39'h0);
        m_cnt <= m_cnt + 1;
      end else begin
        m_phase <= ~m_phase;
        if (enc_ecc_valid) m_r <= {m_r[37:0], 1'b0};
      end
    end
  end

  assign enc_ecc = m_r[38];
  assign enc_ecc_valid = force_ev |
    (enc_valid && (m_cnt >= K) && (stall_mode == 0 || (stall_mode == 1 && m_phase)));

  // Reference codeword for table entries not computed by hand.
  function automatic logic [62:0] ref_cw(input logic [23:0] m);
    logic [38:0] r;
    logic        fb;
    r = '0;
    for (int i = 23; i >= 0; i--) begin
      fb = m[i] ^ r[38];
      r  = {r[37:0], 1'b0} ^ (fb ? G_LOW : 39'h0);
    end
    return {m, r};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] msg;
    int          stall;
    int          hold;
    logic [62:0] exp_cw;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!msg_ready && n < 200) begin @(negedge clk); n++; end
    chk({tag, " ready"}, {63'd0, msg_ready}, 64'd1);
  endtask

  task automatic wait_cw(input string tag);
    int n = 0;
    while (!cw_valid && n < 400) begin @(negedge clk); n++; end
    chk({tag, " cw_valid seen"}, {63'd0, cw_valid}, 64'd1);
  endtask

  // Close a handshake already set up this cycle and check the clear pulse.
  task automatic finish_hs(input string tag);
    int clrs;
    @(negedge clk);
    chk({tag, " cw_valid drop"}, {63'd0, cw_valid}, 64'd0);
    clrs = int'(enc_clr);
    @(negedge clk);
    clrs += int'(enc_clr);
    chk({tag, " enc_clr pulses"}, 64'(clrs), 64'd1);
    chk({tag, " back to idle"}, {63'd0, msg_ready}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int acc;
    stall_mode = v.stall;
    wait_ready(tag);
    msg_in = v.msg; msg_valid = 1'b1; cw_ready = (v.hold == 0); acc = cyc;
    @(negedge clk);
    msg_valid = 1'b0;
    chk({tag, " busy"}, {63'd0, msg_ready}, 64'd0);
    wait_cw(tag);
    chk({tag, " latency"}, 64'(cyc - acc), 64'(v.lat));
    chk({tag, " cw_out"}, {1'b0, cw_out}, {1'b0, v.exp_cw});
    chk({tag, " out enc_valid"}, {63'd0, enc_valid}, 64'd0);
    if (v.hold > 0) begin
      force_ev = 1'b1;  // spurious parity strobes in OUT must be ignored
      for (int h = 1; h < v.hold; h++) begin
        @(negedge clk);
        chk({tag, " hold valid"}, {63'd0, cw_valid}, 64'd1);
        chk({tag, " hold cw"}, {1'b0, cw_out}, {1'b0, v.exp_cw});
      end
      force_ev = 1'b0;
      cw_ready = 1'b1;
    end
    finish_hs(tag);
    stall_mode = 0;
  endtask

  // Second message held valid during a codeword is taken only in IDLE.
  task automatic scen_backpressure();
    int acc, acc2, n;
    wait_ready("s2");
    msg_in = 24'h000000; msg_valid = 1'b1; cw_ready = 1'b1; acc = cyc;
    @(negedge clk);
    msg_in = 24'h000003;
    chk("s2 busy", {63'd0, msg_ready}, 64'd0);
    wait_cw("s2a");
    chk("s2a latency", 64'(cyc - acc), 64'd64);
    chk("s2a cw_out", {1'b0, cw_out}, 64'd0);
    n = 0;
    while (!msg_ready && n < 20) begin @(negedge clk); n++; end
    acc2 = cyc;
    chk("s2 second accept spacing", 64'(acc2 - acc), 64'd66);
    @(negedge clk);
    msg_valid = 1'b0;
    wait_cw("s2b");
    chk("s2b latency", 64'(cyc - acc2), 64'd64);
    chk("s2b cw_out", {1'b0, cw_out}, 64'h000001ED35841242);
    finish_hs("s2b");
  endtask

  // Reset pulse in the middle of the message phase.
  task automatic scen_mid_reset();
    wait_ready("s5");
    msg_in = 24'h0F0F0F; msg_valid = 1'b1; cw_ready = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("s5 in msg", {61'd0, dbg_state}, {61'd0, ST_MSG});
    rst = 1'b1;
    #1;
    chk("s5 rst msg_ready", {63'd0, msg_ready}, 64'd0);
    chk("s5 rst enc_valid", {63'd0, enc_valid}, 64'd0);
    chk("s5 rst enc_data", {63'd0, enc_data}, 64'd0);
    chk("s5 rst enc_clr", {63'd0, enc_clr}, 64'd0);
    chk("s5 rst cw_valid", {63'd0, cw_valid}, 64'd0);
    @(negedge clk);
    chk("s5 rst cw_out", {1'b0, cw_out}, 64'd0);
    chk("s5 state clr", {61'd0, dbg_state}, {61'd0, ST_CLR});
    rst = 1'b0;
    #1;
    chk("s5 enc_clr pulse", {63'd0, enc_clr}, 64'd1);
    chk("s5 no cw_valid", {63'd0, cw_valid}, 64'd0);
    @(negedge clk);
    chk("s5 enc_clr single", {63'd0, enc_clr}, 64'd0);
    chk("s5 idle", {63'd0, msg_ready}, 64'd1);
    run_vec(vecs[0], "s5 recover");
  endtask

`ifdef BCH_FRAMER_TIMEOUT_EN
  task automatic scen_timeout();
    int acc, n;
    logic seen_cw;
    stall_mode = 2;
    wait_ready("s6");
    msg_in = 24'h000005; msg_valid = 1'b1; cw_ready = 1'b1; acc = cyc;
    @(negedge clk);
    msg_valid = 1'b0;
    seen_cw = 1'b0;
    n = 0;
    while (dbg_state != ST_CLR && n < 100) begin
      seen_cw |= cw_valid;
      @(negedge clk); n++;
    end
    chk("s6 abandon cycle", 64'(cyc - acc), 64'd33);
    chk("s6 err_timeout", {63'd0, err_timeout}, 64'd1);
    chk("s6 no cw_valid", {63'd0, seen_cw}, 64'd0);
    stall_mode = 0;
    @(negedge clk);
    chk("s6 idle", {63'd0, msg_ready}, 64'd1);
    run_vec(vecs[0], "s6 recover");
    chk("s6 err sticky", {63'd0, err_timeout}, 64'd1);
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{msg: 24'h000001, stall: 0, hold: 0, exp_cw: 63'h00000F69AC20921, lat: 64};
    vecs[1] = '{msg: 24'h000002, stall: 0, hold: 0, exp_cw: 63'h0000011BAF461B63, lat: 64};
    vecs[2] = '{msg: 24'h000003, stall: 0, hold: 0, exp_cw: 63'h000001ED35841242, lat: 64};
    vecs[3] = '{msg: 24'h000001, stall: 1, hold: 0, exp_cw: 63'h00000F69AC20921, lat: 103};
    vecs[4] = '{msg: 24'hA5C3E1, stall: 0, hold: 20, exp_cw: ref_cw(24'hA5C3E1), lat: 64};
    vecs[5] = '{msg: 24'hFFFFFF, stall: 1, hold: 3, exp_cw: ref_cw(24'hFFFFFF), lat: 103};

    repeat (3) @(negedge clk);
    chk("reset msg_ready", {63'd0, msg_ready}, 64'd0);
    chk("reset enc_data", {63'd0, enc_data}, 64'd0);
    chk("reset enc_valid", {63'd0, enc_valid}, 64'd0);
    chk("reset enc_clr", {63'd0, enc_clr}, 64'd0);
    chk("reset cw_out", {1'b0, cw_out}, 64'd0);
    chk("reset cw_valid", {63'd0, cw_valid}, 64'd0);
    chk("reset err_timeout", {63'd0, err_timeout}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post-reset enc_clr", {63'd0, enc_clr}, 64'd1);
    chk("post-reset state", {61'd0, dbg_state}, {61'd0, ST_CLR});
    @(negedge clk);
    chk("post-reset clr single", {63'd0, enc_clr}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    scen_backpressure();
    scen_mid_reset();
`ifdef BCH_FRAMER_TIMEOUT_EN
    scen_timeout();
`else
    chk("err_timeout tied low", {63'd0, err_timeout}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
